q100_csr_file: RTL and testbench
================================

# q100_csr_file

Machine-mode CSR storage for the Q100 RV32I core, and the receiving end of the WB stage's CSR write port (valid, 12-bit address, 32-bit value). It holds the architectural CSRs, runs the 64-bit cycle and instret counters, and applies trap entry and `mret` updates. It serves one combinational read port to EX, with same-cycle write forwarding.

## Interface
- `HARTID`, 0: value returned by `mhartid`.
- `MTVEC_RESET`, 32'h0000_0000: reset value of `mtvec`; bits [1:0] are ignored.
- `MISA_VAL`, 32'h4000_0100: constant returned by `misa` (RV32I).

- `clk` in 1: single clock; every state update happens on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `csr_vld_i` in 1: CSR write strobe from WB.
- `csr_addr_i` in `LEN_CSR_ADDR` (12): write address.
- `csr_value_i` in `LEN_REG_VAL` (32): write data, already the final value computed for CSRRW/S/C.
- `retire_i` in 1: one instruction retired this cycle.
- `trap_i` in 1: trap entry this cycle.
- `trap_cause_i` in 32: mcause value for the trap.
- `trap_pc_i` in 32: PC of the trapping instruction.
- `mret_i` in 1: `mret` commits this cycle.
- `rd_addr_i` in 12: read address from EX.
- `rd_data_o` out 32: read data (combinational).
- `rd_illegal_o` out 1: `rd_addr_i` is unimplemented (combinational).
- `mtvec_o` out 32: current trap vector, to the fetch unit.
- `mepc_o` out 32: current `mepc`, to the fetch unit for `mret`.
- `mie_o` out 1: `mstatus.MIE`.

## Operation
Implemented CSRs (any other address reads 0 with `rd_illegal_o`=1, and writes to it are dropped):
- `mstatus` 0x300
  - Writable bits: MIE[3] and MPIE[7].
  - MPP[12:11] always reads 2'b11.
  - All other bits read 0.
- `misa` 0x301: reads `MISA_VAL`; writes are ignored.
- `mie` 0x304: 32-bit, fully writable.
- `mtvec` 0x305: writable; bits [1:0] are forced to 0 (direct mode only).
- `mscratch` 0x340: 32-bit, fully writable.
- `mepc` 0x341: writable; bits [1:0] are forced to 0.
- `mcause` 0x342: 32-bit, fully writable.
- Counters, writable in M-mode: `mcycle` 0xB00 / `mcycleh` 0xB80 and `minstret` 0xB02 / `minstreth` 0xB82.
- Read-only counter shadows: `cycle` 0xC00, `cycleh` 0xC80, `instret` 0xC02, `instreth` 0xC82. Writes to them are dropped.
- `mhartid` 0xF14: reads `HARTID`; writes are ignored.

Counters:
- The 64-bit cycle counter increments every cycle that is not in reset.
- The 64-bit instret counter increments on each cycle with `retire_i`=1.
- Both wrap from 2^64-1 to 0.

Update priority per cycle, highest first:
1. `rst`.
2. `trap_i`:
   - `mepc` <= `trap_pc_i` & ~3.
   - `mcause` <= `trap_cause_i`.
   - MPIE <= MIE; MIE <= 0.
   - Any CSR write in the same cycle is dropped entirely.
3. `mret_i`: MIE <= MPIE; MPIE <= 1. A simultaneous write to `mstatus` is dropped; writes to other CSRs still apply.
4. `csr_vld_i` write.

Counter-write interaction:
- A write to a counter half overrides that cycle's increment of that half. The other half still takes its carry or increment.
- Example: writing `mcycleh` while the low half wraps leaves high = written value and low = 0.

Read forwarding:
- Applies when `csr_vld_i`=1 and `csr_addr_i`==`rd_addr_i` for a writable address, and no trap or mret suppresses that write.
- `rd_data_o` then returns the value the register will hold after the edge (masked; MPP still 11).
- Counters do not forward. They return the current registered value.

## Timing
- Writes, trap updates and mret updates are visible on the register outputs one cycle after the input cycle.
- `rd_data_o` and `rd_illegal_o` are purely combinational from the read inputs and the current state.
- `mtvec_o`, `mepc_o` and `mie_o` are registered outputs with no bypass.
- Reset values:
  - `mstatus` = 0x0000_1800.
  - `mie`, `mscratch`, `mepc`, `mcause` = 0.
  - `mtvec` = `MTVEC_RESET` & ~3.
  - All counters = 0.
  - Resulting outputs: `mtvec_o` = `MTVEC_RESET` & ~3, `mepc_o` = 0, `mie_o` = 0.
- Reset asserted mid-operation overrides every simultaneous event in that cycle. The counters do not increment in the reset cycle.
- `trap_i` and `mret_i` are never both high. If they are, `trap_i` wins.

## Test plan
- Reset, then read 0x300, 0x301, 0xF14 with `HARTID`=0 -> 0x1800, 0x4000_0100, 0; `mtvec_o`=0.
- Write `mtvec`=0x8000_0007, then read the next cycle -> 0x8000_0004. A same-cycle read of 0x305 also returns 0x8000_0004 via forwarding.
- Write MIE=1; then trap with pc 0x0000_0102, cause 0x0000_000B, plus a simultaneous write `mscratch`=5 -> `mepc`=0x100, `mcause`=0xB, `mstatus`=0x1880, `mscratch` unchanged. Then `mret` -> `mstatus`=0x1888.
- Write `mcycle`=0xFFFF_FFFE and `mcycleh`=0 on consecutive cycles, then run 3 cycles -> `mcycleh` becomes 1 exactly when the low half wraps through 0.
- Pulse `retire_i` 5 times over 9 cycles -> `minstret` increases by 5. A write to `instret` (0xC02) is dropped.
- Read 0x7C0 -> `rd_illegal_o`=1, `rd_data_o`=0. A write to 0x7C0 changes no state.

Source files
------------

// File: rtl/q100_csr_file.sv
// Machine-mode CSR storage for the Q100 RV32I core: architectural CSRs, 64-bit
// cycle/instret counters, trap entry / mret updates and a forwarded read port.
module q100_csr_file #(
    parameter logic [31:0] HARTID       = 32'd0,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0000,
    parameter logic [31:0] MISA_VAL     = 32'h4000_0100,
    localparam int         LEN_CSR_ADDR = 12,
    localparam int         LEN_REG_VAL  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    csr_vld_i,
    input  logic [LEN_CSR_ADDR-1:0] csr_addr_i,
    input  logic [LEN_REG_VAL-1:0]  csr_value_i,
    input  logic                    retire_i,
    input  logic                    trap_i,
    input  logic [31:0]             trap_cause_i,
    input  logic [31:0]             trap_pc_i,
    input  logic                    mret_i,
    input  logic [LEN_CSR_ADDR-1:0] rd_addr_i,
    output logic [31:0]             rd_data_o,
    output logic                    rd_illegal_o,
    output logic [31:0]             mtvec_o,
    output logic [31:0]             mepc_o,
    output logic                    mie_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic        status_mie;
    logic        status_mpie;
    logic [31:0] mie_csr;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;

    logic        wr_en;
    logic        wr_mstatus;
    logic        wr_mie;
    logic        wr_mtvec;
    logic        wr_mscratch;
    logic        wr_mepc;
    logic        wr_mcause;
    logic        wr_mcycle;
    logic        wr_mcycleh;
    logic        wr_minstret;
    logic        wr_minstreth;
    logic        rd_fwd;

    logic [31:0] cycle_lo_next;
    logic [31:0] cycle_hi_next;
    logic [31:0] instret_lo_next;
    logic [31:0] instret_hi_next;
    logic        cycle_carry;
    logic        instret_carry;

    function automatic logic [31:0] fmt_mstatus(input logic p, input logic e);
        return {19'b0, 2'b11, 3'b0, p, 3'b0, e, 3'b0};
    endfunction

    // A trap swallows the whole WB write; mret only blocks the mstatus write.
    assign wr_en        = csr_vld_i && !trap_i;
    assign wr_mstatus   = wr_en && !mret_i && (csr_addr_i == ADDR_MSTATUS);
    assign wr_mie       = wr_en && (csr_addr_i == ADDR_MIE);
    assign wr_mtvec     = wr_en && (csr_addr_i == ADDR_MTVEC);
    assign wr_mscratch  = wr_en && (csr_addr_i == ADDR_MSCRATCH);
    assign wr_mepc      = wr_en && (csr_addr_i == ADDR_MEPC);
    assign wr_mcause    = wr_en && (csr_addr_i == ADDR_MCAUSE);
    assign wr_mcycle    = wr_en && (csr_addr_i == ADDR_MCYCLE);
    assign wr_mcycleh   = wr_en && (csr_addr_i == ADDR_MCYCLEH);
    assign wr_minstret  = wr_en && (csr_addr_i == ADDR_MINSTRET);
    assign wr_minstreth = wr_en && (csr_addr_i == ADDR_MINSTRETH);

    // A written half replaces its increment; the other half still sees the carry.
    assign cycle_carry     = (cycle_cnt[31:0] == ALL_ONES);
    assign cycle_lo_next   = wr_mcycle ? csr_value_i : cycle_cnt[31:0] + 32'd1;
    assign cycle_hi_next   = wr_mcycleh ? csr_value_i
                                        : cycle_cnt[63:32] + {31'b0, cycle_carry};
    assign instret_carry   = retire_i && (instret_cnt[31:0] == ALL_ONES);
    assign instret_lo_next = wr_minstret ? csr_value_i
                                         : instret_cnt[31:0] + {31'b0, retire_i};
    assign instret_hi_next = wr_minstreth ? csr_value_i
                                          : instret_cnt[63:32] + {31'b0, instret_carry};

    always_ff @(posedge clk) begin
        if (rst) begin
            status_mie  <= 1'b0;
            status_mpie <= 1'b0;
        end else if (trap_i) begin
            status_mpie <= status_mie;
            status_mie  <= 1'b0;
        end else if (mret_i) begin
            status_mie  <= status_mpie;
            status_mpie <= 1'b1;
        end else if (wr_mstatus) begin
            status_mie  <= csr_value_i[3];
            status_mpie <= csr_value_i[7];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mepc   <= 32'd0;
            mcause <= 32'd0;
        end else if (trap_i) begin
            mepc   <= {trap_pc_i[31:2], 2'b00};
            mcause <= trap_cause_i;
        end else begin
            if (wr_mepc) begin
                mepc <= {csr_value_i[31:2], 2'b00};
            end
            if (wr_mcause) begin
                mcause <= csr_value_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_csr  <= 32'd0;
            mtvec    <= {MTVEC_RESET[31:2], 2'b00};
            mscratch <= 32'd0;
        end else begin
            if (wr_mie) begin
                mie_csr <= csr_value_i;
            end
            if (wr_mtvec) begin
                mtvec <= {csr_value_i[31:2], 2'b00};
            end
            if (wr_mscratch) begin
                mscratch <= csr_value_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
        end else begin
            cycle_cnt   <= {cycle_hi_next, cycle_lo_next};
            instret_cnt <= {instret_hi_next, instret_lo_next};
        end
    end

    // Forwarding returns the post-edge value of a same-cycle write; counters never forward.
    assign rd_fwd = wr_en && (csr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_o    = 32'd0;
        rd_illegal_o = 1'b0;
        unique case (rd_addr_i)
            ADDR_MSTATUS:   rd_data_o = (rd_fwd && !mret_i)
                                        ? fmt_mstatus(csr_value_i[7], csr_value_i[3])
                                        : fmt_mstatus(status_mpie, status_mie);
            ADDR_MISA:      rd_data_o = MISA_VAL;
            ADDR_MIE:       rd_data_o = rd_fwd ? csr_value_i : mie_csr;
            ADDR_MTVEC:     rd_data_o = rd_fwd ? {csr_value_i[31:2], 2'b00} : mtvec;
            ADDR_MSCRATCH:  rd_data_o = rd_fwd ? csr_value_i : mscratch;
            ADDR_MEPC:      rd_data_o = rd_fwd ? {csr_value_i[31:2], 2'b00} : mepc;
            ADDR_MCAUSE:    rd_data_o = rd_fwd ? csr_value_i : mcause;
            ADDR_MCYCLE,
            ADDR_CYCLE:     rd_data_o = cycle_cnt[31:0];
            ADDR_MCYCLEH,
            ADDR_CYCLEH:    rd_data_o = cycle_cnt[63:32];
            ADDR_MINSTRET,
            ADDR_INSTRET:   rd_data_o = instret_cnt[31:0];
            ADDR_MINSTRETH,
            ADDR_INSTRETH:  rd_data_o = instret_cnt[63:32];
            ADDR_MHARTID:   rd_data_o = HARTID;
            default:        rd_illegal_o = 1'b1;
        endcase
    end

    assign mtvec_o = mtvec;
    assign mepc_o  = mepc;
    assign mie_o   = status_mie;

endmodule

// File: tb/tb_q100_csr_file.sv
// Testbench for q100_csr_file: directed vector table, hand-written counter
// sequences and a randomized phase checked against a behavioural CSR model.
module tb_q100_csr_file;

    localparam logic [31:0] TB_HARTID = 32'd0;
    localparam logic [31:0] TB_MTVEC  = 32'h0000_0000;
    localparam logic [31:0] TB_MISA   = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_vld_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_value_i;
    logic        retire_i;
    logic        trap_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_pc_i;
    logic        mret_i;
    logic [11:0] rd_addr_i;
    logic [31:0] rd_data_o;
    logic        rd_illegal_o;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    q100_csr_file #(
        .HARTID      (TB_HARTID),
        .MTVEC_RESET (TB_MTVEC),
        .MISA_VAL    (TB_MISA)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_vld_i    (csr_vld_i),
        .csr_addr_i   (csr_addr_i),
        .csr_value_i  (csr_value_i),
        .retire_i     (retire_i),
        .trap_i       (trap_i),
        .trap_cause_i (trap_cause_i),
        .trap_pc_i    (trap_pc_i),
        .mret_i       (mret_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_o    (rd_data_o),
        .rd_illegal_o (rd_illegal_o),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .mie_o        (mie_o)
    );

    // Architectural view of the CSR state; counters held as whole 64-bit numbers.
    typedef struct packed {
        logic        mie;
        logic        mpie;
        logic [31:0] mie_csr;
        logic [31:0] mtvec;
        logic [31:0] mscratch;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [63:0] cyc;
        logic [63:0] ins;
    } model_t;

    model_t m;

    typedef struct {
        logic        vld;
        logic [11:0] addr;
        logic [31:0] val;
        logic        trap;
        logic [31:0] cause;
        logic [31:0] pc;
        logic        mret;
        logic [11:0] rd;
        logic [31:0] exp_rd;
        logic        exp_ill;
        logic [31:0] exp_mtvec;
        logic [31:0] exp_mepc;
        logic        exp_mie;
    } vec_t;

    vec_t vecs[19];

    logic [11:0] addr_pool[20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                   12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02,
                                   12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
                                   12'hF14, 12'h7C0, 12'h000, 12'h344, 12'hB03};

    function automatic logic [32:0] csr_view(model_t s, logic [11:0] a);
        case (a)
            12'h300: return {1'b0, 32'h0000_1800 | (32'(s.mpie) << 7) | (32'(s.mie) << 3)};
            12'h301: return {1'b0, TB_MISA};
            12'h304: return {1'b0, s.mie_csr};
            12'h305: return {1'b0, s.mtvec};
            12'h340: return {1'b0, s.mscratch};
            12'h341: return {1'b0, s.mepc};
            12'h342: return {1'b0, s.mcause};
            12'hB00, 12'hC00: return {1'b0, s.cyc[31:0]};
            12'hB80, 12'hC80: return {1'b0, s.cyc[63:32]};
            12'hB02, 12'hC02: return {1'b0, s.ins[31:0]};
            12'hB82, 12'hC82: return {1'b0, s.ins[63:32]};
            12'hF14: return {1'b0, TB_HARTID};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic model_t apply_write(model_t s, logic [11:0] a, logic [31:0] v);
        model_t n = s;
        case (a)
            12'h300: begin n.mie = v[3]; n.mpie = v[7]; end
            12'h304: n.mie_csr = v;
            12'h305: n.mtvec = v & ~32'h3;
            12'h340: n.mscratch = v;
            12'h341: n.mepc = v & ~32'h3;
            12'h342: n.mcause = v;
            12'hB00: n.cyc[31:0] = v;
            12'hB80: n.cyc[63:32] = v;
            12'hB02: n.ins[31:0] = v;
            12'hB82: n.ins[63:32] = v;
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic forwardable(logic [11:0] a);
        return a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342};
    endfunction

    function automatic logic [32:0] expected_read();
        if (csr_vld_i && !trap_i && csr_addr_i == rd_addr_i && forwardable(csr_addr_i)
            && !(mret_i && csr_addr_i == 12'h300))
            return csr_view(apply_write(m, csr_addr_i, csr_value_i), rd_addr_i);
        return csr_view(m, rd_addr_i);
    endfunction

    task automatic model_next();
        model_t n;
        if (rst) begin
            n = '0;
            n.mtvec = TB_MTVEC & ~32'h3;
        end else begin
            n = m;
            n.cyc = m.cyc + 64'd1;
            if (retire_i) n.ins = m.ins + 64'd1;
            if (trap_i) begin
                n.mepc  = trap_pc_i & ~32'h3;
                n.mcause = trap_cause_i;
                n.mpie  = m.mie;
                n.mie   = 1'b0;
            end else begin
                if (mret_i) begin
                    n.mie  = m.mpie;
                    n.mpie = 1'b1;
                end
                if (csr_vld_i && !(mret_i && csr_addr_i == 12'h300))
                    n = apply_write(n, csr_addr_i, csr_value_i);
            end
        end
        m = n;
    endtask

    task automatic applyStimulus(input logic r, input logic vld, input logic [11:0] addr,
                                 input logic [31:0] val, input logic ret, input logic trp,
                                 input logic [31:0] cause, input logic [31:0] pc,
                                 input logic mr, input logic [11:0] rd);
        rst          = r;
        csr_vld_i    = vld;
        csr_addr_i   = addr;
        csr_value_i  = val;
        retire_i     = ret;
        trap_i       = trp;
        trap_cause_i = cause;
        trap_pc_i    = pc;
        mret_i       = mr;
        rd_addr_i    = rd;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        logic [32:0] e;
        e = expected_read();
        checkOutput({tag, " rd_data"}, rd_data_o, e[31:0]);
        checkOutput({tag, " rd_illegal"}, 32'(rd_illegal_o), 32'(e[32]));
        checkOutput({tag, " mtvec_o"}, mtvec_o, m.mtvec);
        checkOutput({tag, " mepc_o"}, mepc_o, m.mepc);
        checkOutput({tag, " mie_o"}, 32'(mie_o), 32'(m.mie));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [8:0]  pat;
        logic [31:0] v;
        logic [11:0] a;
        logic        trp;

        vecs[0]  = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h0000_1800, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1]  = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h301, 32'h4000_0100, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hF14, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 12'h305, 32'h8000_0007, 1'b0, 32'h0, 32'h0, 1'b0, 12'h305, 32'h8000_0004, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[4]  = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h305, 32'h8000_0004, 1'b0, 32'h8000_0004, 32'h0, 1'b0};
        vecs[5]  = '{1'b1, 12'h300, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h0000_1808, 1'b0, 32'h8000_0004, 32'h0, 1'b0};
        vecs[6]  = '{1'b1, 12'h340, 32'h5, 1'b1, 32'hB, 32'h102, 1'b0, 12'h340, 32'h0, 1'b0, 32'h8000_0004, 32'h0, 1'b1};
        vecs[7]  = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h341, 32'h100, 1'b0, 32'h8000_0004, 32'h100, 1'b0};
        vecs[8]  = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h342, 32'hB, 1'b0, 32'h8000_0004, 32'h100, 1'b0};
        vecs[9]  = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h0000_1880, 1'b0, 32'h8000_0004, 32'h100, 1'b0};
        vecs[10] = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h340, 32'h0, 1'b0, 32'h8000_0004, 32'h100, 1'b0};
        vecs[11] = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 12'h300, 32'h0000_1880, 1'b0, 32'h8000_0004, 32'h100, 1'b0};
        vecs[12] = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h0000_1888, 1'b0, 32'h8000_0004, 32'h100, 1'b1};
        vecs[13] = '{1'b1, 12'h300, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 12'h300, 32'h0000_1888, 1'b0, 32'h8000_0004, 32'h100, 1'b1};
        vecs[14] = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300, 32'h0000_1888, 1'b0, 32'h8000_0004, 32'h100, 1'b1};
        vecs[15] = '{1'b1, 12'h7C0, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b0, 12'h7C0, 32'h0, 1'b1, 32'h8000_0004, 32'h100, 1'b1};
        vecs[16] = '{1'b1, 12'h341, 32'h1234_5677, 1'b0, 32'h0, 32'h0, 1'b0, 12'h341, 32'h1234_5674, 1'b0, 32'h8000_0004, 32'h100, 1'b1};
        vecs[17] = '{1'b1, 12'hC02, 32'h1234, 1'b0, 32'h0, 32'h0, 1'b0, 12'hC02, 32'h0, 1'b0, 32'h8000_0004, 32'h1234_5674, 1'b1};
        vecs[18] = '{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hB02, 32'h0, 1'b0, 32'h8000_0004, 32'h1234_5674, 1'b1};

        m = '0;
        applyStimulus(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300);
        @(negedge clk);
        tick();
        tick();

        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b0, vecs[i].vld, vecs[i].addr, vecs[i].val, 1'b0, vecs[i].trap,
                          vecs[i].cause, vecs[i].pc, vecs[i].mret, vecs[i].rd);
            checkOutput($sformatf("vec%0d rd_data", i), rd_data_o, vecs[i].exp_rd);
            checkOutput($sformatf("vec%0d rd_illegal", i), 32'(rd_illegal_o), 32'(vecs[i].exp_ill));
            checkOutput($sformatf("vec%0d mtvec_o", i), mtvec_o, vecs[i].exp_mtvec);
            checkOutput($sformatf("vec%0d mepc_o", i), mepc_o, vecs[i].exp_mepc);
            checkOutput($sformatf("vec%0d mie_o", i), 32'(mie_o), 32'(vecs[i].exp_mie));
            tick();
        end

        // Five retires over nine cycles, with a dropped write to the instret shadow.
        pat = 9'b1_0011_0101;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, i == 3, 12'hC02, 32'h0000_FFFF, pat[i], 1'b0, 32'h0, 32'h0, 1'b0, 12'hB02);
            if (i == 0) checkOutput("instret start", rd_data_o, 32'd0);
            if (i == 3) checkOutput("instret mid", rd_data_o, 32'd2);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hB02);
        checkOutput("instret after 5", rd_data_o, 32'd5);
        tick();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hB82);
        checkOutput("instreth", rd_data_o, 32'd0);
        tick();

        // mcycle low half wraps into the high half.
        applyStimulus(1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300);
        tick();
        applyStimulus(1'b0, 1'b1, 12'hB80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hB00);
        checkOutput("mcycle written", rd_data_o, 32'hFFFF_FFFE);
        tick();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hB80);
        checkOutput("mcycleh before wrap", rd_data_o, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hB80);
        checkOutput("mcycleh after wrap", rd_data_o, 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hC00);
        checkOutput("cycle shadow", rd_data_o, 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hC80);
        checkOutput("cycleh shadow", rd_data_o, 32'd1);
        tick();

        // Writing the high half while the low half wraps: written value wins.
        applyStimulus(1'b0, 1'b1, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'h300);
        tick();
        applyStimulus(1'b0, 1'b1, 12'hB80, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hB00);
        checkOutput("mcycle all ones", rd_data_o, 32'hFFFF_FFFF);
        tick();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hB80);
        checkOutput("mcycleh override", rd_data_o, 32'd7);
        tick();
        applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 12'hB00);
        checkOutput("mcycle after override", rd_data_o, 32'd1);
        tick();

        // Randomized traffic against the behavioural model.
        for (int i = 0; i < 400; i++) begin
            a = addr_pool[$urandom_range(0, 19)];
            v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
            trp = ($urandom_range(0, 7) == 0);
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, a, v,
                          $urandom_range(0, 1) == 1, trp, $urandom, $urandom,
                          ($urandom_range(0, 7) == 0) && (!trp || $urandom_range(0, 3) == 0),
                          ($urandom_range(0, 1) == 1) ? a : addr_pool[$urandom_range(0, 19)]);
            check_model($sformatf("rand%0d", i));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
